seq_pattern_gen: RTL and testbench

Serial pattern transmitter, the source side of the team's serial sequence detectors. On a start pulse it emits a fixed MSB-first bit pattern (default 1101100) on a one-bit serial line a programmable number of times, with a programmable number of idle zero bits between repetitions. Its `seq` output connects directly to a detector's `seq` input for self-checking link tests and bring-up.

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_dcnt.sv | 37 +++
 rtl/seq_pattern_gen.sv | 169 ++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator: FSM states,
// default pattern and field widths.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam int unsigned DEF_PAT_LEN = 7;
    localparam logic [6:0]  SEQ_1101100 = 7'b1101100;
    localparam int unsigned GAP_W       = 4;

endpackage

// File: rtl/seq_dcnt.sv
// Loadable down-counter with enable and zero flag; load has priority
// over enable.
module seq_dcnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends PATTERN MSB-first `reps` times with
// `gap` idle zero bits between repetitions; all outputs registered.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int unsigned         PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0]  PATTERN = SEQ_1101100,
    parameter int unsigned         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] reps,
    input  logic [3:0]       gap,
    output logic             seq,
    output logic             valid,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int unsigned        IDX_W    = $clog2(PAT_LEN);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(PAT_LEN - 1);

    state_e             state_q, state_d;
    logic [GAP_W-1:0]   gap_lat_q, gap_lat_d;
    logic               seq_q, seq_d;
    logic               valid_q, valid_d;
    logic               frame_q, frame_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               idx_load, idx_en, idx_zero;
    logic [IDX_W-1:0]   idx_cnt, idx_nxt;
    logic               gap_load, gap_en, gap_zero;
    logic               rep_load, rep_en, rep_zero;
    logic [GAP_W-1:0]   unused_gap_cnt;
    logic [CNT_W-1:0]   unused_rep_cnt;

    // Repetition and gap counters hold "remaining minus one" so the zero
    // flag marks the last repetition / last gap cycle.
    seq_dcnt #(.W(IDX_W)) u_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (idx_load),
        .en       (idx_en),
        .load_val (IDX_LAST),
        .cnt      (idx_cnt),
        .zero     (idx_zero)
    );

    seq_dcnt #(.W(GAP_W)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .en       (gap_en),
        .load_val (gap_lat_q - GAP_W'(1)),
        .cnt      (unused_gap_cnt),
        .zero     (gap_zero)
    );

    seq_dcnt #(.W(CNT_W)) u_rep (
        .clk      (clk),
        .rst      (rst),
        .load     (rep_load),
        .en       (rep_en),
        .load_val (reps - CNT_W'(1)),
        .cnt      (unused_rep_cnt),
        .zero     (rep_zero)
    );

    always_comb begin
        state_d   = state_q;
        gap_lat_d = gap_lat_q;
        idx_load  = 1'b0;
        idx_en    = 1'b0;
        gap_load  = 1'b0;
        gap_en    = 1'b0;
        rep_load  = 1'b0;
        rep_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (reps != '0) begin
                        gap_lat_d = gap;
                        rep_load  = 1'b1;
                        idx_load  = 1'b1;
                        state_d   = SEND;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = DONE;
                end else if (idx_zero) begin
                    if (rep_zero) begin
                        state_d = DONE;
                    end else begin
                        rep_en = 1'b1;
                        if (gap_lat_q == '0) begin
                            idx_load = 1'b1;
                        end else begin
                            gap_load = 1'b1;
                            state_d  = GAP;
                        end
                    end
                end else begin
                    idx_en = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = DONE;
                end else if (gap_zero) begin
                    idx_load = 1'b1;
                    state_d  = SEND;
                end else begin
                    gap_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state
        // and the index value the counter is about to take.
        idx_nxt = idx_load ? IDX_LAST : (idx_en ? idx_cnt - IDX_W'(1) : idx_cnt);
        valid_d = (state_d == SEND);
        seq_d   = valid_d && PATTERN[idx_nxt];
        frame_d = valid_d && idx_load;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gap_lat_q <= '0;
            seq_q     <= 1'b0;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_lat_q <= gap_lat_d;
            seq_q     <= seq_d;
            valid_q   <= valid_d;
            frame_q   <= frame_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign seq   = seq_q;
    assign valid = valid_q;
    assign frame = frame_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: the stimulus queues the expected
// per-cycle output stream, a negedge monitor pops and compares it.
module tb_seq_pattern_gen;

    localparam int unsigned PAT_LEN = 7;
    localparam int unsigned CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] reps;
    logic [3:0]       gap;
    logic             seq, valid, frame, busy, done;

    typedef struct packed {
        logic seq;
        logic valid;
        logic frame;
        logic busy;
        logic done;
    } obs_t;

    obs_t        exp_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [6:0]  pat     = 7'b1101100;

    seq_pattern_gen #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (7'b1101100),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .reps  (reps),
        .gap   (gap),
        .seq   (seq),
        .valid (valid),
        .frame (frame),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // An empty queue means the block must be idle with every output low.
    always @(negedge clk) begin
        obs_t act;
        obs_t e;
        act = {seq, valid, frame, busy, done};
        e   = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL stream t=%0t seq/valid/frame/busy/done actual=%b expected=%b",
                     $time, act, e);
        end
    end

    // Reference: whole-transfer stream from the pattern rules, truncated at
    // the abort cycle, followed by the single done cycle.
    task automatic push_expected(input int unsigned r, input int unsigned g,
                                 input int unsigned abort_at);
        obs_t s[$];
        obs_t o;
        for (int unsigned k = 0; k < r; k++) begin
            for (int b = PAT_LEN - 1; b >= 0; b--) begin
                o       = '0;
                o.seq   = pat[b];
                o.valid = 1'b1;
                o.frame = (b == PAT_LEN - 1);
                o.busy  = 1'b1;
                s.push_back(o);
            end
            if (k + 1 < r) begin
                for (int unsigned j = 0; j < g; j++) begin
                    o      = '0;
                    o.busy = 1'b1;
                    s.push_back(o);
                end
            end
        end
        if (abort_at != 0) begin
            while (s.size() > abort_at) void'(s.pop_back());
        end
        o      = '0;
        o.busy = 1'b1;
        o.done = 1'b1;
        s.push_back(o);
        foreach (s[i]) exp_q.push_back(s[i]);
    endtask

    task automatic run(input int unsigned r, input int unsigned g,
                       input int unsigned abort_at, input bit abort_with_start,
                       input bit poke_start);
        int unsigned len;
        len = (r == 0) ? 1 : r * PAT_LEN + (r - 1) * g + 1;
        if (abort_at != 0) len = abort_at + 1;
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = abort_with_start;
        reps  = CNT_W'(r);
        gap   = 4'(g);
        @(posedge clk);
        push_expected(r, g, abort_at);
        #1;
        start = 1'b0;
        abort = 1'b0;
        reps  = CNT_W'($urandom);
        gap   = 4'($urandom);
        for (int unsigned c = 1; c <= len + 8; c++) begin
            abort = (abort_at != 0) && (c == abort_at);
            start = poke_start && (c == 3);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        abort = 1'b0;
        start = 1'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain reps=%0d gap=%0d left=%0d required=0", r, g, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic reset_mid_gap();
        @(posedge clk);
        #1;
        start = 1'b1;
        reps  = CNT_W'(3);
        gap   = 4'd5;
        @(posedge clk);
        push_expected(3, 5, 0);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        reps  = '0;
        gap   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);

        run(1, 0, 0, 1'b0, 1'b0);
        run(3, 2, 0, 1'b0, 1'b0);
        run(0, 0, 0, 1'b0, 1'b0);
        run(2, 3, 0, 1'b0, 1'b1);
        run(4, 1, 12, 1'b0, 1'b0);
        run(1, 0, 0, 1'b1, 1'b0);
        reset_mid_gap();
        run(1, 0, 0, 1'b0, 1'b0);
        run(255, 0, 0, 1'b0, 1'b0);
        run(2, 15, 0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            int unsigned r, g, tx, ab;
            r  = $urandom_range(0, 6);
            g  = $urandom_range(0, 15);
            tx = (r == 0) ? 0 : r * PAT_LEN + (r - 1) * g;
            ab = 0;
            if (r != 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, tx);
            run(r, g, ab, 1'(($urandom_range(0, 3) == 0)), 1'(($urandom_range(0, 3) == 0)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
